// File: rtl/snake_pkg.sv
// Shared encodings for the snake movement controller: FSM states, directions
// and the PS/2 make codes that act as commands.
package snake_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DEAD,
    ST_BLANK
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  localparam logic [7:0] KEY_UP      = 8'h75;
  localparam logic [7:0] KEY_DOWN    = 8'h72;
  localparam logic [7:0] KEY_LEFT    = 8'h6B;
  localparam logic [7:0] KEY_RIGHT   = 8'h74;
  localparam logic [7:0] KEY_PAUSE   = 8'h4D;
  localparam logic [7:0] KEY_RESUME  = 8'h2D;
  localparam logic [7:0] KEY_BLANK   = 8'h76;
  localparam logic [7:0] KEY_RESTART = 8'h1B;

  function automatic logic is_opposite(input dir_t a, input dir_t b);
    return ((a == DIR_UP)   && (b == DIR_DOWN))  ||
           ((a == DIR_DOWN) && (b == DIR_UP))    ||
           ((a == DIR_LEFT) && (b == DIR_RIGHT)) ||
           ((a == DIR_RIGHT) && (b == DIR_LEFT));
  endfunction

endpackage

// File: rtl/snake_if.sv
// Keyboard/control inputs and packed segment coordinates between the
// controller (slave) and its surroundings (master).
interface snake_if #(
  parameter int MAX_LEN = 8,
  parameter int CW      = 10,
  parameter int LW      = $clog2(MAX_LEN + 1)
) ();
  logic [7:0]            scancode;
  logic                  strobe;
  logic                  speed_sel;
  logic                  grow;
  logic [MAX_LEN*CW-1:0] seg_x;
  logic [MAX_LEN*CW-1:0] seg_y;
  logic [LW-1:0]         length;
  logic                  blackout;
  logic                  dead;
  logic                  paused;
  logic                  move;

  modport master (
    output scancode, strobe, speed_sel, grow,
    input  seg_x, seg_y, length, blackout, dead, paused, move
  );

  modport slave (
    input  scancode, strobe, speed_sel, grow,
    output seg_x, seg_y, length, blackout, dead, paused, move
  );
endinterface

// File: rtl/snake_tick_gen.sv
// Move-rate divider: tick is high while the counter sits at DIV-1, with DIV
// chosen every cycle by speed_sel; clear_i restarts the period.
module snake_tick_gen #(
  parameter int SLOW_DIV = 10_000_000,
  parameter int FAST_DIV = 5_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear_i,
  input  logic speed_sel_i,
  output logic tick_o
);
  localparam int MAXD  = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int CNT_W = $clog2(MAXD + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] lim;

  assign lim    = speed_sel_i ? CNT_W'(FAST_DIV - 1) : CNT_W'(SLOW_DIV - 1);
  // >= so a switch to the fast rate with the counter past its limit still fires
  assign tick_o = (cnt_q >= lim);

  always_ff @(posedge CLK) begin
    if (RST || clear_i) begin
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/snake_ctrl_param.sv
// Snake movement controller: decodes scancodes into commands, steps the head
// on each tick, shifts the body and detects wall/self collisions.
module snake_ctrl_param
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 8,
  parameter int INIT_LEN = 4,
  parameter int CW       = 10,
  parameter int STEP     = 10,
  parameter int X_MIN    = 4,
  parameter int X_MAX    = 634,
  parameter int Y_MIN    = 4,
  parameter int Y_MAX    = 474,
  parameter int START_X  = 34,
  parameter int START_Y  = 104,
  parameter int SLOW_DIV = 10_000_000,
  parameter int FAST_DIV = 5_000_000
) (
  input logic   CLK,
  input logic   RST,
  snake_if.slave bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic signed [CW:0] STEP_S  = (CW+1)'(STEP);
  localparam logic signed [CW:0] X_MIN_S = (CW+1)'(X_MIN);
  localparam logic signed [CW:0] X_MAX_S = (CW+1)'(X_MAX);
  localparam logic signed [CW:0] Y_MIN_S = (CW+1)'(Y_MIN);
  localparam logic signed [CW:0] Y_MAX_S = (CW+1)'(Y_MAX);

  state_t        state_q;
  dir_t          dir_q, pend_q, key_dir, cmp_dir;
  logic [LW-1:0] len_q, hit_last;
  logic          grow_pend_q, move_q, dead_q, paused_q, blackout_q;
  logic          tick, wall, self_hit, growing;
  logic          key_restart, key_blank, key_pause, key_resume, key_dir_valid;
  logic          do_restart, do_blank, do_shift;
  logic signed [CW:0] nx, ny;
  logic [CW-1:0] seg_x_w [MAX_LEN];
  logic [CW-1:0] seg_y_w [MAX_LEN];
  logic [MAX_LEN-1:0] hit_vec;

  snake_tick_gen #(
    .SLOW_DIV (SLOW_DIV),
    .FAST_DIV (FAST_DIV)
  ) u_tick (
    .CLK         (CLK),
    .RST         (RST),
    .clear_i     (do_restart),
    .speed_sel_i (bus.speed_sel),
    .tick_o      (tick)
  );

  always_comb begin
    key_restart   = 1'b0;
    key_blank     = 1'b0;
    key_pause     = 1'b0;
    key_resume    = 1'b0;
    key_dir_valid = 1'b0;
    key_dir       = DIR_RIGHT;
    if (bus.strobe) begin
      case (bus.scancode)
        KEY_UP:      begin key_dir_valid = 1'b1; key_dir = DIR_UP;    end
        KEY_DOWN:    begin key_dir_valid = 1'b1; key_dir = DIR_DOWN;  end
        KEY_LEFT:    begin key_dir_valid = 1'b1; key_dir = DIR_LEFT;  end
        KEY_RIGHT:   begin key_dir_valid = 1'b1; key_dir = DIR_RIGHT; end
        KEY_PAUSE:   key_pause   = 1'b1;
        KEY_RESUME:  key_resume  = 1'b1;
        KEY_BLANK:   key_blank   = 1'b1;
        KEY_RESTART: key_restart = 1'b1;
        default:     ;
      endcase
    end
  end

  // One extra signed bit so stepping left/up past zero reads as a wall hit.
  always_comb begin
    nx = $signed({1'b0, seg_x_w[0]});
    ny = $signed({1'b0, seg_y_w[0]});
    case (pend_q)
      DIR_UP:    ny = ny - STEP_S;
      DIR_DOWN:  ny = ny + STEP_S;
      DIR_LEFT:  nx = nx - STEP_S;
      default:   nx = nx + STEP_S;
    endcase
  end

  assign wall     = (nx < X_MIN_S) || (nx > X_MAX_S) || (ny < Y_MIN_S) || (ny > Y_MAX_S);
  assign growing  = grow_pend_q && (len_q < LW'(MAX_LEN));
  // The tail only counts as an obstacle when it will not move away this tick.
  assign hit_last = growing ? (len_q - LW'(1)) : (len_q - LW'(2));
  assign self_hit = |hit_vec;

  assign do_restart = key_restart;
  assign do_blank   = key_blank;
  assign do_shift   = (state_q == ST_RUN) && tick && !wall && !self_hit &&
                      !do_restart && !do_blank;
  assign cmp_dir    = do_shift ? pend_q : dir_q;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_seg
      localparam int IDX = (gi < INIT_LEN) ? gi : (INIT_LEN - 1);
      localparam logic [CW-1:0] RST_X = CW'(START_X - IDX * STEP);
      localparam logic [CW-1:0] RST_Y = CW'(START_Y);
      logic [CW-1:0] x_q, y_q;

      if (gi == 0) begin : g_head
        always_ff @(posedge CLK) begin
          if (RST || do_restart) begin
            x_q <= RST_X;
            y_q <= RST_Y;
          end else if (do_shift) begin
            x_q <= nx[CW-1:0];
            y_q <= ny[CW-1:0];
          end
        end
        assign hit_vec[gi] = 1'b0;
      end else begin : g_body
        always_ff @(posedge CLK) begin
          if (RST || do_restart) begin
            x_q <= RST_X;
            y_q <= RST_Y;
          end else if (do_shift) begin
            x_q <= seg_x_w[gi-1];
            y_q <= seg_y_w[gi-1];
          end
        end
        assign hit_vec[gi] = (LW'(gi) <= hit_last) &&
                             (x_q == nx[CW-1:0]) && (y_q == ny[CW-1:0]);
      end

      assign seg_x_w[gi]             = x_q;
      assign seg_y_w[gi]             = y_q;
      assign bus.seg_x[gi*CW +: CW]  = x_q;
      assign bus.seg_y[gi*CW +: CW]  = y_q;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST || do_restart) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_RIGHT;
      pend_q      <= DIR_RIGHT;
      len_q       <= LW'(INIT_LEN);
      grow_pend_q <= 1'b0;
      move_q      <= 1'b0;
      dead_q      <= 1'b0;
      paused_q    <= 1'b0;
      blackout_q  <= 1'b0;
    end else begin
      move_q <= do_shift;
      if (do_shift) begin
        dir_q       <= pend_q;
        grow_pend_q <= 1'b0;
        if (growing) begin
          len_q <= len_q + LW'(1);
        end
      end
      if (bus.grow && (len_q < LW'(MAX_LEN))) begin
        grow_pend_q <= 1'b1;
      end
      if (key_dir_valid && (state_q inside {ST_IDLE, ST_RUN, ST_PAUSE}) &&
          !is_opposite(key_dir, cmp_dir)) begin
        pend_q <= key_dir;
      end
      if (do_blank) begin
        state_q    <= ST_BLANK;
        blackout_q <= 1'b1;
        dead_q     <= 1'b0;
        paused_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (tick) state_q <= ST_RUN;
          ST_RUN: begin
            if (tick && (wall || self_hit)) begin
              state_q <= ST_DEAD;
              dead_q  <= 1'b1;
            end else if (key_pause) begin
              state_q  <= ST_PAUSE;
              paused_q <= 1'b1;
            end
          end
          ST_PAUSE: begin
            if (key_resume) begin
              state_q  <= ST_RUN;
              paused_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.length   = len_q;
  assign bus.blackout = blackout_q;
  assign bus.dead     = dead_q;
  assign bus.paused   = paused_q;
  assign bus.move     = move_q;
endmodule

// File: tb/tb_snake_ctrl_param.sv
// Directed bench for snake_ctrl_param with short move periods (4 / 2 cycles).
module tb_snake_ctrl_param;
  localparam int CW = 10;
  localparam int ML = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snake_if #(.MAX_LEN(ML), .CW(CW)) bus ();

  snake_ctrl_param #(
    .MAX_LEN(ML), .INIT_LEN(4), .CW(CW), .STEP(10),
    .X_MIN(4), .X_MAX(634), .Y_MIN(4), .Y_MAX(474),
    .START_X(34), .START_Y(104), .SLOW_DIV(4), .FAST_DIV(2)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  logic [CW-1:0] sx [ML];
  logic [CW-1:0] sy [ML];
  for (genvar gi = 0; gi < ML; gi++) begin : g_view
    assign sx[gi] = bus.seg_x[gi*CW +: CW];
    assign sy[gi] = bus.seg_y[gi*CW +: CW];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input logic [7:0] code);
    bus.scancode = code;
    bus.strobe   = 1'b1;
    @(negedge clk);
    bus.strobe   = 1'b0;
    $display("[TB] key %02h -> head (%0d,%0d) len %0d", code, sx[0], sy[0], bus.length);
  endtask

  task automatic pulse_grow();
    bus.grow = 1'b1;
    @(negedge clk);
    bus.grow = 1'b0;
  endtask

  task automatic wait_move(input int budget, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    while (cycles < budget && !ok) begin
      @(negedge clk);
      cycles++;
      if (bus.move) ok = 1'b1;
    end
    $display("[TB] move after %0d cycles ok=%0d head (%0d,%0d) len %0d", cycles, ok, sx[0], sy[0], bus.length);
  endtask

  task automatic count_moves(input int n, output int moves);
    moves = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.move) moves++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    n_tests++; if (bus.length !== 4'd4) begin n_fail++; $display("FAIL reset_len: got %0d want 4", bus.length); end
    n_tests++; if (sx[0] !== 10'd34 || sy[0] !== 10'd104) begin n_fail++; $display("FAIL reset_head: got (%0d,%0d) want (34,104)", sx[0], sy[0]); end
    n_tests++; if (sx[1] !== 10'd24 || sx[3] !== 10'd4) begin n_fail++; $display("FAIL reset_body: got seg1 %0d seg3 %0d want 24 4", sx[1], sx[3]); end
    n_tests++; if (sx[7] !== 10'd4 || sy[7] !== 10'd104) begin n_fail++; $display("FAIL reset_spare: got (%0d,%0d) want (4,104)", sx[7], sy[7]); end
    n_tests++; if ({bus.blackout, bus.dead, bus.paused, bus.move} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {bus.blackout, bus.dead, bus.paused, bus.move}); end
  endtask

  task automatic test_run();
    bit ok; int c; int m;
    wait_move(20, ok, c);
    n_tests++; if (!ok || c !== 8) begin n_fail++; $display("FAIL run_first_move: got ok=%0d cycles %0d want ok=1 cycles 8", ok, c); end
    n_tests++; if (sx[0] !== 10'd44 || sx[1] !== 10'd34 || bus.length !== 4'd4) begin n_fail++; $display("FAIL run_step1: got head %0d seg1 %0d len %0d want 44 34 4", sx[0], sx[1], bus.length); end
    wait_move(20, ok, c);
    n_tests++; if (!ok || sx[0] !== 10'd54 || sx[1] !== 10'd44) begin n_fail++; $display("FAIL run_step2: got head %0d seg1 %0d want 54 44", sx[0], sx[1]); end
    count_moves(8, m);
    n_tests++; if (m !== 2 || sx[0] !== 10'd74) begin n_fail++; $display("FAIL run_rate: got %0d moves head %0d want 2 moves head 74", m, sx[0]); end
  endtask

  task automatic test_dir();
    bit ok; int c;
    key(8'h6B);
    wait_move(20, ok, c);
    n_tests++; if (!ok || sx[0] !== 10'd84 || sy[0] !== 10'd104) begin n_fail++; $display("FAIL dir_reverse: got (%0d,%0d) want (84,104)", sx[0], sy[0]); end
    key(8'h75);
    wait_move(20, ok, c);
    n_tests++; if (!ok || sx[0] !== 10'd84 || sy[0] !== 10'd94) begin n_fail++; $display("FAIL dir_up: got (%0d,%0d) want (84,94)", sx[0], sy[0]); end
    cyc(3);
    key(8'h6B);
    n_tests++; if (bus.move !== 1'b1 || sx[0] !== 10'd84 || sy[0] !== 10'd84) begin n_fail++; $display("FAIL dir_tick_key: got move %0d (%0d,%0d) want move 1 (84,84)", bus.move, sx[0], sy[0]); end
    wait_move(20, ok, c);
    n_tests++; if (!ok || sx[0] !== 10'd74 || sy[0] !== 10'd84) begin n_fail++; $display("FAIL dir_left_next: got (%0d,%0d) want (74,84)", sx[0], sy[0]); end
  endtask

  task automatic test_wall();
    bit ok; int c; int m;
    key(8'h1B);
    n_tests++; if (sx[0] !== 10'd34 || sy[0] !== 10'd104 || bus.length !== 4'd4) begin n_fail++; $display("FAIL wall_restart1: got (%0d,%0d) len %0d want (34,104) len 4", sx[0], sy[0], bus.length); end
    for (int k = 0; k < 70 && sx[0] !== 10'd634; k++) begin
      wait_move(20, ok, c);
    end
    n_tests++; if (sx[0] !== 10'd634) begin n_fail++; $display("FAIL wall_reach: got x %0d want 634", sx[0]); end
    cyc(4);
    n_tests++; if (bus.dead !== 1'b1) begin n_fail++; $display("FAIL wall_dead: got %0d want 1", bus.dead); end
    count_moves(8, m);
    n_tests++; if (m !== 0 || sx[0] !== 10'd634 || sx[1] !== 10'd624 || sy[0] !== 10'd104) begin n_fail++; $display("FAIL wall_frozen: got moves %0d head %0d seg1 %0d y %0d want 0 634 624 104", m, sx[0], sx[1], sy[0]); end
    key(8'h1B);
    n_tests++; if (sx[0] !== 10'd34 || sy[0] !== 10'd104 || bus.dead !== 1'b0) begin n_fail++; $display("FAIL wall_restart2: got (%0d,%0d) dead %0d want (34,104) 0", sx[0], sy[0], bus.dead); end
    wait_move(20, ok, c);
    n_tests++; if (!ok || c !== 8 || sx[0] !== 10'd44) begin n_fail++; $display("FAIL wall_idle: got cycles %0d head %0d want 8 44", c, sx[0]); end
  endtask

  task automatic test_grow();
    bit ok; int c;
    pulse_grow();
    wait_move(20, ok, c);
    n_tests++; if (!ok || bus.length !== 4'd5 || sx[4] !== 10'd14 || sx[0] !== 10'd54) begin n_fail++; $display("FAIL grow_one: got len %0d seg4 %0d head %0d want 5 14 54", bus.length, sx[4], sx[0]); end
    for (int k = 0; k < 3; k++) begin
      pulse_grow();
      wait_move(20, ok, c);
    end
    n_tests++; if (bus.length !== 4'd8 || sx[7] !== 10'd14) begin n_fail++; $display("FAIL grow_max: got len %0d seg7 %0d want 8 14", bus.length, sx[7]); end
    pulse_grow();
    wait_move(20, ok, c);
    n_tests++; if (!ok || bus.length !== 4'd8 || sx[0] !== 10'd94) begin n_fail++; $display("FAIL grow_cap: got len %0d head %0d want 8 94", bus.length, sx[0]); end
  endtask

  task automatic test_self_hit();
    bit ok; int c;
    key(8'h1B);
    wait_move(20, ok, c);
    pulse_grow();
    wait_move(20, ok, c);
    key(8'h75);
    wait_move(20, ok, c);
    key(8'h6B);
    wait_move(20, ok, c);
    n_tests++; if (sx[0] !== 10'd44 || sy[0] !== 10'd94 || bus.length !== 4'd5) begin n_fail++; $display("FAIL self_path: got (%0d,%0d) len %0d want (44,94) 5", sx[0], sy[0], bus.length); end
    key(8'h72);
    cyc(3);
    n_tests++; if (bus.dead !== 1'b1 || sx[0] !== 10'd44 || sy[0] !== 10'd94) begin n_fail++; $display("FAIL self_dead: got dead %0d (%0d,%0d) want 1 (44,94)", bus.dead, sx[0], sy[0]); end
  endtask

  task automatic test_pause();
    bit ok; int c; int m;
    key(8'h1B);
    wait_move(20, ok, c);
    key(8'h4D);
    n_tests++; if (bus.paused !== 1'b1) begin n_fail++; $display("FAIL pause_flag: got %0d want 1", bus.paused); end
    count_moves(12, m);
    n_tests++; if (m !== 0 || sx[0] !== 10'd44) begin n_fail++; $display("FAIL pause_frozen: got moves %0d head %0d want 0 44", m, sx[0]); end
    key(8'h2D);
    n_tests++; if (bus.paused !== 1'b0) begin n_fail++; $display("FAIL resume_flag: got %0d want 0", bus.paused); end
    wait_move(20, ok, c);
    n_tests++; if (!ok || sx[0] !== 10'd54) begin n_fail++; $display("FAIL resume_move: got head %0d want 54", sx[0]); end
  endtask

  task automatic test_blank();
    bit ok; int c; int m;
    key(8'h76);
    n_tests++; if (bus.blackout !== 1'b1) begin n_fail++; $display("FAIL blank_flag: got %0d want 1", bus.blackout); end
    count_moves(8, m);
    key(8'h75);
    n_tests++; if (m !== 0 || sx[0] !== 10'd54 || sy[0] !== 10'd104) begin n_fail++; $display("FAIL blank_frozen: got moves %0d (%0d,%0d) want 0 (54,104)", m, sx[0], sy[0]); end
    key(8'h1B);
    n_tests++; if (bus.blackout !== 1'b0 || sx[0] !== 10'd34 || sy[0] !== 10'd104) begin n_fail++; $display("FAIL blank_restart: got blackout %0d (%0d,%0d) want 0 (34,104)", bus.blackout, sx[0], sy[0]); end
    wait_move(20, ok, c);
    n_tests++; if (!ok || sx[0] !== 10'd44 || sy[0] !== 10'd104) begin n_fail++; $display("FAIL blank_after: got (%0d,%0d) want (44,104)", sx[0], sy[0]); end
  endtask

  task automatic test_speed();
    bit ok; int c;
    wait_move(20, ok, c);
    n_tests++; if (!ok || c !== 4) begin n_fail++; $display("FAIL speed_slow: got period %0d want 4", c); end
    bus.speed_sel = 1'b1;
    wait_move(20, ok, c);
    wait_move(20, ok, c);
    n_tests++; if (!ok || c !== 2) begin n_fail++; $display("FAIL speed_fast: got period %0d want 2", c); end
    bus.speed_sel = 1'b0;
  endtask

  task automatic test_reset_mid_move();
    bit ok; int c;
    wait_move(20, ok, c);
    cyc(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (bus.move !== 1'b0 || sx[0] !== 10'd34 || sy[0] !== 10'd104 || bus.length !== 4'd4) begin n_fail++; $display("FAIL reset_mid: got move %0d (%0d,%0d) len %0d want 0 (34,104) 4", bus.move, sx[0], sy[0], bus.length); end
  endtask

  initial begin
    rst           = 1'b1;
    bus.scancode  = 8'h00;
    bus.strobe    = 1'b0;
    bus.speed_sel = 1'b0;
    bus.grow      = 1'b0;
    @(negedge clk);
    test_reset();
    test_run();
    test_dir();
    test_wall();
    test_grow();
    test_self_hit();
    test_pause();
    test_blank();
    test_speed();
    test_reset_mid_move();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
